// File: rtl/coin_acceptor_if.sv
// Coin-slot interface: raw sensor lines in, clean one-hot coin protocol out to soda_machine.
interface coin_acceptor_if;
  logic       coin_nickel_raw;
  logic       coin_dime_raw;
  logic       coin_quarter_raw;
  logic       Nickel;
  logic       Dime;
  logic       Quarter;
  logic       Insert_money;
  logic       jam;
  logic [7:0] coin_count;

  // The acceptor drives the coin protocol from the sensor lines.
  modport master (
    input  coin_nickel_raw, coin_dime_raw, coin_quarter_raw,
    output Nickel, Dime, Quarter, Insert_money, jam, coin_count
  );

  // Sensor side / coin consumer.
  modport slave (
    output coin_nickel_raw, coin_dime_raw, coin_quarter_raw,
    input  Nickel, Dime, Quarter, Insert_money, jam, coin_count
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces coin sensors, rejects glitches and jams,
// and emits one setup cycle plus one Insert_money strobe per physical coin.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            reset,
  coin_acceptor_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DEBOUNCE = 3'd1;
  localparam logic [2:0] SETUP    = 3'd2;
  localparam logic [2:0] STROBE   = 3'd3;
  localparam logic [2:0] RELEASE  = 3'd4;
  localparam logic [2:0] JAM      = 3'd5;

  localparam logic [7:0] DEB_LIMIT  = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] HOLD_LIMIT = 8'(HOLDOFF_CYCLES);

  function automatic logic is_one_hot(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'd1)) == 3'b000);
  endfunction

  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [1:0] warm_q;
  logic [2:0] s;
  logic       s_valid;

  assign raw = {bus.coin_quarter_raw, bus.coin_dime_raw, bus.coin_nickel_raw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      warm_q  <= 2'b00;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      warm_q  <= {warm_q[0], 1'b1};
    end
  end

  // The cleared synchronizer reads as zero until refilled; those samples must not
  // satisfy the holdoff, otherwise a coin held through reset would be accepted.
  assign s       = sync2_q;
  assign s_valid = warm_q[1];

  logic [2:0] state_q, state_d;
  logic [2:0] cap_q, cap_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        hold_d = 8'd0;
        if (s != 3'b000) begin
          cap_d = s;
          cnt_d = 8'd1;
          if (DEB_LIMIT == 8'd1) state_d = is_one_hot(s) ? SETUP : JAM;
          else                   state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (s == cap_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == DEB_LIMIT) state_d = is_one_hot(cap_q) ? SETUP : JAM;
        end else if (s == 3'b000) begin
          state_d = IDLE;
        end else begin
          cap_d = s;
          cnt_d = 8'd1;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = RELEASE;
      RELEASE, JAM: begin
        if (s_valid) begin
          if (s != 3'b000) begin
            hold_d = 8'd0;
          end else if (hold_q + 8'd1 == HOLD_LIMIT) begin
            hold_d  = 8'd0;
            state_d = IDLE;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: state_d = RELEASE;
    endcase
  end

  logic [2:0] line_q, line_d;
  logic       insert_q, jam_q;
  logic [7:0] count_q;

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  assign line_d = (state_d == SETUP || state_d == STROBE) ? cap_d : 3'b000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RELEASE;
      cap_q    <= 3'b000;
      cnt_q    <= 8'd0;
      hold_q   <= 8'd0;
      line_q   <= 3'b000;
      insert_q <= 1'b0;
      jam_q    <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      line_q   <= line_d;
      insert_q <= (state_d == STROBE);
      jam_q    <= (state_d == JAM);
      if (state_d == STROBE && count_q != 8'hFF) count_q <= count_q + 8'd1;
    end
  end

  assign bus.Nickel       = line_q[0];
  assign bus.Dime         = line_q[1];
  assign bus.Quarter      = line_q[2];
  assign bus.Insert_money = insert_q;
  assign bus.jam          = jam_q;
  assign bus.coin_count   = count_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed latency/jam/holdoff/reset/saturation
// scenarios plus randomized presses checked against a per-press reference model.
module tb_coin_acceptor;
  localparam int D   = 4;
  localparam int H   = 2;
  localparam int GAP = D + H + 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  coin_acceptor_if bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int inv_bad  = 0;
  int exp_count = 0;
  logic [2:0] got_q[$];
  logic [2:0] exp_q[$];

  // Monitor: record every strobe's coin line and the one-hot invariants.
  always @(negedge clk) begin
    automatic int ones = int'(bus.Nickel) + int'(bus.Dime) + int'(bus.Quarter);
    if (ones > 1) inv_bad++;
    if (bus.Insert_money && ones != 1) inv_bad++;
    if (bus.Insert_money && bus.jam) inv_bad++;
    if (bus.Insert_money) got_q.push_back({bus.Quarter, bus.Dime, bus.Nickel});
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [2:0] v);
    bus.coin_nickel_raw  = v[0];
    bus.coin_dime_raw    = v[1];
    bus.coin_quarter_raw = v[2];
  endtask

  task automatic press(input logic [2:0] v, input int len, input int gap);
    set_raw(v);
    repeat (len) tick();
    set_raw(3'b000);
    repeat (gap) tick();
  endtask

  function automatic int sat_inc(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  initial begin
    logic [2:0] v;
    int len;
    int kind;
    bit found;

    set_raw(3'b000);
    // Reset state
    #12;
    check("rst_nickel", 32'(bus.Nickel), 0);
    check("rst_dime", 32'(bus.Dime), 0);
    check("rst_quarter", 32'(bus.Quarter), 0);
    check("rst_insert", 32'(bus.Insert_money), 0);
    check("rst_jam", 32'(bus.jam), 0);
    check("rst_count", 32'(bus.coin_count), 0);
    tick();
    reset = 1'b1;
    repeat (6) tick();

    // Clean dime: cycle-exact latency
    got_q.delete();
    set_raw(3'b010);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 10) set_raw(3'b000);
      check($sformatf("dime_line_k%0d", k), 32'(bus.Dime), (k >= D + 2 && k < D + 4) ? 1 : 0);
      check($sformatf("dime_ins_k%0d", k), 32'(bus.Insert_money), (k == D + 3) ? 1 : 0);
      check($sformatf("dime_other_k%0d", k), 32'(bus.Nickel | bus.Quarter), 0);
    end
    repeat (GAP) tick();
    exp_count = sat_inc(exp_count);
    check("dime_count", 32'(bus.coin_count), exp_count);
    check("dime_strobes", got_q.size(), 1);

    // Glitch then bounce restart
    got_q.delete();
    press(3'b001, 3, 1);
    press(3'b001, 8, GAP);
    exp_count = sat_inc(exp_count);
    check("glitch_strobes", got_q.size(), 1);
    if (got_q.size() >= 1) check("glitch_type", 32'(got_q[0]), 1);
    check("glitch_count", 32'(bus.coin_count), exp_count);

    // Jam: dime + quarter together
    got_q.delete();
    set_raw(3'b110);
    for (int k = 1; k <= 10 + H + 5; k++) begin
      tick();
      if (k == 10) set_raw(3'b000);
      check($sformatf("jam_k%0d", k), 32'(bus.jam), (k >= D + 2 && k <= 10 + 1 + H) ? 1 : 0);
    end
    repeat (GAP) tick();
    check("jam_strobes", got_q.size(), 0);
    check("jam_count", 32'(bus.coin_count), exp_count);

    // Long hold with a gap shorter than the holdoff
    got_q.delete();
    press(3'b100, 50, 1);
    press(3'b100, 10, GAP);
    exp_count = sat_inc(exp_count);
    check("hold_strobes", got_q.size(), 1);
    if (got_q.size() >= 1) check("hold_type", 32'(got_q[0]), 4);
    check("hold_count", 32'(bus.coin_count), exp_count);

    // Randomized presses: each clean one-hot press of >= D cycles yields exactly one strobe
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        v = 3'b001 << $urandom_range(0, 2);
        len = $urandom_range(D, D + 15);
        exp_q.push_back(v);
        exp_count = sat_inc(exp_count);
      end else if (kind == 1) begin
        v = 3'($urandom_range(1, 7));
        len = $urandom_range(1, D - 1);
      end else begin
        case ($urandom_range(0, 3))
          0: v = 3'b011;
          1: v = 3'b101;
          2: v = 3'b110;
          default: v = 3'b111;
        endcase
        len = $urandom_range(D, D + 10);
      end
      press(v, len, GAP + $urandom_range(0, 4));
    end
    check("rand_strobes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_type_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("rand_count", 32'(bus.coin_count), exp_count);

    // Reset during STROBE with the sensor held
    set_raw(3'b100);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (bus.Insert_money) found = 1'b1;
    end
    check("rst_strobe_seen", 32'(found), 1);
    #2 reset = 1'b0;
    #1;
    got_q.delete();
    exp_count = 0;
    check("arst_quarter", 32'(bus.Quarter), 0);
    check("arst_insert", 32'(bus.Insert_money), 0);
    check("arst_count", 32'(bus.coin_count), 0);
    tick();
    tick();
    reset = 1'b1;
    repeat (20) tick();
    check("held_no_strobe", got_q.size(), 0);
    check("held_line", 32'(bus.Quarter), 0);
    set_raw(3'b000);
    repeat (H + 6) tick();
    press(3'b100, D + 1, GAP);
    exp_count = sat_inc(exp_count);
    check("post_rst_strobes", got_q.size(), 1);
    check("post_rst_count", 32'(bus.coin_count), exp_count);

    // Saturation: 260 clean nickels
    got_q.delete();
    for (int i = 0; i < 260; i++) begin
      press(3'b001, D, GAP);
      exp_count = sat_inc(exp_count);
      if (exp_count >= 254) check($sformatf("sat_count_%0d", i), 32'(bus.coin_count), exp_count);
    end
    check("sat_final", 32'(bus.coin_count), 255);
    check("sat_strobes", got_q.size(), 260);

    check("invariants", inv_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front end feeding soda_machine: turns raw, bouncy, asynchronous coin-slot sensor lines into the clean coin protocol soda_machine consumes.
- The protocol is one-hot Nickel/Dime/Quarter held stable, plus a single-cycle Insert_money strobe.
- Rejects glitches and flags simultaneous-coin jams.
- Enforces a release/holdoff gap so a single physical coin is never counted twice.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples required to accept a coin; legal range 1..255.
- HOLDOFF_CYCLES, 2: consecutive all-zero synchronized samples required before a new coin is accepted; legal range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_nickel_raw  in  1  asynchronous nickel sensor, high while coin present.
- coin_dime_raw  in  1  asynchronous dime sensor.
- coin_quarter_raw  in  1  asynchronous quarter sensor.
- Nickel  out  1  to soda_machine; one-hot coin line.
- Dime  out  1  to soda_machine; one-hot coin line.
- Quarter  out  1  to soda_machine; one-hot coin line.
- Insert_money  out  1  to soda_machine; one-cycle strobe, coin line valid.
- jam  out  1  high while a multi-coin event is being rejected.
- coin_count  out  8  accepted coins since reset, saturating.

Behaviour:
- Synchronizer: 2-flop synchronizer per raw line, cleared by reset. s = synchronized 3-bit vector {quarter, dime, nickel}.
- Registered outputs: all outputs are registered. Reset (reset=0, async) forces Nickel, Dime, Quarter, Insert_money, jam to 0, coin_count to 0, counters to 0, FSM to RELEASE.
- Held coin at reset release: a coin held through reset is ignored until s returns to 0 for HOLDOFF_CYCLES.
- States: IDLE, DEBOUNCE, SETUP, STROBE, RELEASE, JAM.
- IDLE: outputs 0. At an edge with s != 0, capture cap = s, set cnt = 1, go to DEBOUNCE.
- DEBOUNCE, edge with s == cap: cnt++. When cnt reaches DEBOUNCE_CYCLES:
  - go SETUP if cap is one-hot;
  - go JAM if cap has 2 or more bits set.
- DEBOUNCE, edge with s != cap:
  - s == 0: back to IDLE, glitch discarded.
  - otherwise: cap = s, cnt = 1 (bounce restarts qualification).
- DEBOUNCE_CYCLES = 1: the IDLE capture sample alone qualifies. The transition goes straight to SETUP/JAM.
- SETUP: drive the coin line matching cap; Insert_money = 0. Lasts exactly 1 cycle. This gives soda_machine a full cycle of setup on the coin line.
- STROBE: coin line still held, Insert_money = 1, exactly 1 cycle. On entry, coin_count increments, saturating at 255 (no wrap).
- RELEASE: all coin lines and Insert_money = 0. Holdoff counter increments on each s == 0 sample and clears on any s != 0 sample. Reaching HOLDOFF_CYCLES goes to IDLE.
- Sensor held indefinitely in RELEASE: no second strobe.
- JAM: jam = 1, coin lines 0, Insert_money never asserted, coin_count unchanged. Exits via the same holdoff rule as RELEASE; jam drops on the edge entering IDLE.
- Latency, raw high sampled at edge 1 and stable:
  - s valid at edge 2; IDLE capture at edge 3;
  - coin line rises after edge 2+DEBOUNCE_CYCLES;
  - Insert_money high for the cycle after edge 3+DEBOUNCE_CYCLES;
  - both low after edge 4+DEBOUNCE_CYCLES.
  - Defaults: coin edge 6, strobe edge 7, drop edge 8.
- Simultaneous events:
  - Raw pulses shorter than DEBOUNCE_CYCLES are never reported.
  - Changes in s during SETUP/STROBE are ignored; the sequence completes.
  - At most one coin line is ever high; Insert_money is never high without exactly one coin line high.
- Reset mid-SETUP/STROBE: strobe aborted immediately, count not incremented if reset precedes the STROBE entry edge.

Test Plan:
- Clean dime: coin_dime_raw high 10 cycles from edge 1 → Dime high edges 6–8, Insert_money high only cycle after edge 7, coin_count=1, Nickel=Quarter=0 throughout.
- Glitch and bounce: nickel raw high 3 cycles, low, then high 8 cycles → first pulse ignored, exactly one Nickel/Insert_money strobe, coin_count=1.
- Jam: dime and quarter raw high together 10 cycles → jam=1 from edge 6 until 2 cycles after both drop, no Insert_money, coin_count=0.
- Long hold and holdoff: quarter held 50 cycles, released 1 cycle, held again 10 cycles → one strobe per qualified press only; 1-cycle gap (< HOLDOFF_CYCLES) yields no second strobe, coin_count=1.
- Saturation: 260 clean nickels → coin_count stops at 255, strobes continue.
- Reset: assert reset during STROBE and while sensor held → outputs 0 asynchronously, coin_count=0, no strobe until sensor released ≥2 cycles and a new coin is qualified.
